// File: rtl/score_record_display.sv
// Score record keeper and display driver: snapshots the final score on death,
// tracks the best score, blinks on a new record and drives three active-low 7-segment digits.
module score_record_display #(
  parameter int BLINKS = 3
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic       clearBest,
  input  logic       death,
  input  logic       outofbounddeath,
  input  logic [3:0] hundredsDigit,
  input  logic [3:0] tensDigit,
  input  logic [3:0] unitsDigit,
  input  logic       tick,
  input  logic       showBest,
  output logic [6:0] HEX2,
  output logic [6:0] HEX1,
  output logic [6:0] HEX0,
  output logic       newRecord,
  output logic [3:0] bestHundreds,
  output logic [3:0] bestTens,
  output logic [3:0] bestUnits
);

  typedef enum logic [1:0] {PLAY, COMPARE, CELEBRATE, OVER} state_t;

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [3:0] BLINK_TICKS = 4'(2 * BLINKS);

  state_t     state;
  logic       dead, dead_prev, rise;
  logic [3:0] snap_h, snap_t, snap_u;
  logic       phase;
  logic [3:0] blink_count;

  logic [3:0] src_h, src_t, src_u;
  logic       blank_h, blank_t, blink_off;
  logic [6:0] hex2_next, hex1_next, hex0_next;

  function automatic logic [3:0] sanitize(input logic [3:0] d);
    return (d > 4'd9) ? 4'd0 : d;
  endfunction

  function automatic logic [6:0] seg(input logic [3:0] d);
    case (d)
      4'd0:    return 7'h40;
      4'd1:    return 7'h79;
      4'd2:    return 7'h24;
      4'd3:    return 7'h30;
      4'd4:    return 7'h19;
      4'd5:    return 7'h12;
      4'd6:    return 7'h02;
      4'd7:    return 7'h78;
      4'd8:    return 7'h00;
      4'd9:    return 7'h10;
      default: return SEG_BLANK;
    endcase
  endfunction

  assign dead = death | outofbounddeath;
  assign rise = dead & ~dead_prev;

  // Display source selection, leading-zero blanking and blink masking
  always_comb begin
    src_h     = showBest ? bestHundreds : hundredsDigit;
    src_t     = showBest ? bestTens     : tensDigit;
    src_u     = showBest ? bestUnits    : unitsDigit;
    blank_h   = (src_h == 4'd0);
    blank_t   = blank_h && (src_t == 4'd0);
    blink_off = (state == CELEBRATE) && !phase;
    hex2_next = (blank_h || blink_off) ? SEG_BLANK : seg(src_h);
    hex1_next = (blank_t || blink_off) ? SEG_BLANK : seg(src_t);
    hex0_next = blink_off ? SEG_BLANK : seg(src_u);
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state       <= PLAY;
      dead_prev   <= 1'b0;
      snap_h      <= 4'd0;
      snap_t      <= 4'd0;
      snap_u      <= 4'd0;
      newRecord   <= 1'b0;
      phase       <= 1'b1;
      blink_count <= 4'd0;
      HEX2        <= SEG_BLANK;
      HEX1        <= SEG_BLANK;
      HEX0        <= 7'h40;
      if (clearBest) begin
        bestHundreds <= 4'd0;
        bestTens     <= 4'd0;
        bestUnits    <= 4'd0;
      end
    end else begin
      dead_prev <= dead;
      HEX2      <= hex2_next;
      HEX1      <= hex1_next;
      HEX0      <= hex0_next;
      case (state)
        PLAY: begin
          if (rise) begin
            snap_h <= sanitize(hundredsDigit);
            snap_t <= sanitize(tensDigit);
            snap_u <= sanitize(unitsDigit);
            state  <= COMPARE;
          end
        end
        COMPARE: begin
          // Valid BCD digits concatenated compare in the same order as the decimal value
          if ({snap_h, snap_t, snap_u} > {bestHundreds, bestTens, bestUnits}) begin
            bestHundreds <= snap_h;
            bestTens     <= snap_t;
            bestUnits    <= snap_u;
            newRecord    <= 1'b1;
            blink_count  <= BLINK_TICKS;
            phase        <= 1'b1;
            state        <= CELEBRATE;
          end else begin
            state <= OVER;
          end
        end
        CELEBRATE: begin
          if (tick) begin
            blink_count <= blink_count - 4'd1;
            if (blink_count <= 4'd1) begin
              phase <= 1'b1;
              state <= OVER;
            end else begin
              phase <= ~phase;
            end
          end
        end
        OVER: begin
          if (!dead) begin
            newRecord <= 1'b0;
            state     <= PLAY;
          end
        end
        default: state <= PLAY;
      endcase
    end
  end

endmodule

// File: tb/tb_score_record_display.sv
// Directed self-checking bench for score_record_display with hand-computed expected values.
module tb_score_record_display;

  logic       Clock = 1'b0;
  logic       Reset, clearBest, death, outofbounddeath;
  logic [3:0] hundredsDigit, tensDigit, unitsDigit;
  logic       tick, showBest;
  logic [6:0] HEX2, HEX1, HEX0;
  logic       newRecord;
  logic [3:0] bestHundreds, bestTens, bestUnits;

  int checks = 0;
  int errors = 0;

  score_record_display #(.BLINKS(3)) dut (
    .Clock(Clock), .Reset(Reset), .clearBest(clearBest),
    .death(death), .outofbounddeath(outofbounddeath),
    .hundredsDigit(hundredsDigit), .tensDigit(tensDigit), .unitsDigit(unitsDigit),
    .tick(tick), .showBest(showBest),
    .HEX2(HEX2), .HEX1(HEX1), .HEX0(HEX0),
    .newRecord(newRecord),
    .bestHundreds(bestHundreds), .bestTens(bestTens), .bestUnits(bestUnits)
  );

  always #5 Clock = ~Clock;

  // Advance n clock edges, then settle 1 time unit past the edge
  task automatic step(input int n);
    repeat (n) @(posedge Clock);
    #1;
  endtask

  task automatic set_digits(input logic [3:0] h, input logic [3:0] t, input logic [3:0] u);
    hundredsDigit = h;
    tensDigit     = t;
    unitsDigit    = u;
  endtask

  task automatic check_output(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic check_hex(input string tag, input logic [6:0] h2, input logic [6:0] h1, input logic [6:0] h0);
    check_output(tag, {11'd0, HEX2, HEX1, HEX0}, {11'd0, h2, h1, h0});
  endtask

  task automatic check_best(input string tag, input logic [11:0] b);
    check_output(tag, {20'd0, bestHundreds, bestTens, bestUnits}, {20'd0, b});
  endtask

  task automatic pulse_tick();
    tick = 1'b1;
    step(1);
    tick = 1'b0;
  endtask

  initial begin
    Reset = 1'b1; clearBest = 1'b1; death = 1'b0; outofbounddeath = 1'b0;
    tick = 1'b0; showBest = 1'b0;
    set_digits(4'd0, 4'd0, 4'd0);
    step(2);
    check_hex("reset_hex", 7'h7F, 7'h7F, 7'h40);
    check_best("reset_best", 12'h000);
    check_output("reset_newrecord", 32'(newRecord), 32'd0);
    Reset = 1'b0; clearBest = 1'b0;
    step(1);
    check_hex("idle_live_000", 7'h7F, 7'h7F, 7'h40);

    // New record 047 with a full blink sequence
    set_digits(4'd0, 4'd4, 4'd7);
    step(1);
    death = 1'b1;
    step(1);
    check_best("best_not_yet_at_compare", 12'h000);
    step(1);
    check_best("record_047", 12'h047);
    check_output("record_flag", 32'(newRecord), 32'd1);
    step(1);
    check_hex("celebrate_on", 7'h7F, 7'h19, 7'h78);
    for (int i = 1; i <= 6; i++) begin
      pulse_tick();
      step(1);
      if (i % 2 == 1) check_hex($sformatf("blink_off_%0d", i), 7'h7F, 7'h7F, 7'h7F);
      else            check_hex($sformatf("blink_on_%0d", i), 7'h7F, 7'h19, 7'h78);
    end
    pulse_tick();
    step(1);
    check_hex("over_ignores_tick", 7'h7F, 7'h19, 7'h78);
    check_output("over_holds_record", 32'(newRecord), 32'd1);
    death = 1'b0;
    step(2);
    check_output("record_clears", 32'(newRecord), 32'd0);

    // Equal score is not a record
    outofbounddeath = 1'b1;
    step(3);
    check_best("equal_best_kept", 12'h047);
    check_output("equal_no_flag", 32'(newRecord), 32'd0);
    pulse_tick();
    step(1);
    check_hex("equal_no_blink", 7'h7F, 7'h19, 7'h78);
    outofbounddeath = 1'b0;
    step(2);

    // Display source selection
    set_digits(4'd1, 4'd0, 4'd5);
    showBest = 1'b1;
    step(1);
    check_hex("show_best", 7'h7F, 7'h19, 7'h78);
    showBest = 1'b0;
    step(1);
    check_hex("show_live_105", 7'h79, 7'h40, 7'h12);

    // Invalid units digit: sanitized to 0 for snapshot, blank on display
    set_digits(4'd0, 4'd0, 4'hF);
    death = 1'b1;
    step(3);
    check_best("invalid_no_record", 12'h047);
    check_output("invalid_no_flag", 32'(newRecord), 32'd0);
    check_hex("invalid_units_blank", 7'h7F, 7'h7F, 7'h7F);
    death = 1'b0;
    step(2);

    // Record 120, then Reset without clearBest mid-blink
    set_digits(4'd1, 4'd2, 4'd0);
    death = 1'b1;
    step(3);
    check_best("record_120", 12'h120);
    check_hex("celebrate_120_on", 7'h79, 7'h24, 7'h40);
    pulse_tick();
    step(1);
    check_hex("celebrate_120_off", 7'h7F, 7'h7F, 7'h7F);
    Reset = 1'b1; clearBest = 1'b0; death = 1'b0;
    step(1);
    check_output("abort_newrecord", 32'(newRecord), 32'd0);
    check_best("abort_best_kept", 12'h120);
    check_hex("abort_hex", 7'h7F, 7'h7F, 7'h40);
    Reset = 1'b0;
    step(1);
    check_hex("after_abort_live", 7'h79, 7'h24, 7'h40);
    Reset = 1'b1; clearBest = 1'b1;
    step(1);
    check_best("clear_best", 12'h000);
    Reset = 1'b0; clearBest = 1'b0;
    step(1);

    // Both flags rising together, then hand-over with no gap keeps OVER
    set_digits(4'd0, 4'd0, 4'd3);
    death = 1'b1; outofbounddeath = 1'b1;
    step(3);
    check_best("dual_rise_record", 12'h003);
    for (int i = 0; i < 6; i++) pulse_tick();
    death = 1'b0;
    step(2);
    check_output("handover_stays_over", 32'(newRecord), 32'd1);
    outofbounddeath = 1'b0;
    step(2);
    check_output("handover_release", 32'(newRecord), 32'd0);
    check_best("handover_best", 12'h003);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
